display_pattern_decoder: RTL

// Receiving end of the 7-segment path: reads a Display[6:0] segment pattern, as produced by Display from

---
 rtl/display_pattern_decoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/display_pattern_decoder.sv
// Recovers a hex digit from a 7-segment pattern once it has been stable for STABLE_CYCLES clocks.
// Illegal patterns and captures that never settle are reported on Error and counted in ErrorCount.
module display_pattern_decoder #(
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned TIMEOUT       = 64,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [6:0] Display,
    input  logic       Ready,
    output logic [3:0] Output,
    output logic       Valid,
    output logic       Error,
    output logic       Busy,
    output logic [7:0] ErrorCount
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StDone
    } state_e;

    state_e            state_q;
    logic [6:0]        ref_q;
    logic [CntW-1:0]   stable_q;
    logic [CntW-1:0]   timeout_q;

    logic [6:0]        seg;
    logic [CntW-1:0]   stable_inc;
    logic [CntW-1:0]   timeout_inc;
    logic              matched;
    logic              stable_hit;
    logic              timeout_hit;
    logic [4:0]        ref_decoded;
    logic              ref_legal;
    logic [3:0]        ref_value;
    logic [7:0]        err_count_inc;

    // Returns {legal, value}; every pattern outside the hex table is illegal.
    function automatic logic [4:0] decode(input logic [6:0] pattern);
        logic [4:0] result;
        case (pattern)
            7'h3F:   result = {1'b1, 4'h0};
            7'h06:   result = {1'b1, 4'h1};
            7'h5B:   result = {1'b1, 4'h2};
            7'h4F:   result = {1'b1, 4'h3};
            7'h66:   result = {1'b1, 4'h4};
            7'h6D:   result = {1'b1, 4'h5};
            7'h7D:   result = {1'b1, 4'h6};
            7'h07:   result = {1'b1, 4'h7};
            7'h7F:   result = {1'b1, 4'h8};
            7'h6F:   result = {1'b1, 4'h9};
            7'h77:   result = {1'b1, 4'hA};
            7'h7C:   result = {1'b1, 4'hB};
            7'h39:   result = {1'b1, 4'hC};
            7'h5E:   result = {1'b1, 4'hD};
            7'h79:   result = {1'b1, 4'hE};
            7'h71:   result = {1'b1, 4'hF};
            default: result = {1'b0, 4'h0};
        endcase
        return result;
    endfunction

    // All comparisons and decoding work on the active-high view of the segments.
    assign seg = ACTIVE_LOW ? ~Display : Display;

    assign stable_inc  = stable_q + CntW'(1);
    assign timeout_inc = timeout_q + CntW'(1);
    assign matched     = (seg == ref_q);
    assign stable_hit  = matched && (stable_inc == CntW'(STABLE_CYCLES));
    assign timeout_hit = (timeout_inc == CntW'(TIMEOUT));

    assign ref_decoded = decode(ref_q);
    assign ref_legal   = ref_decoded[4];
    assign ref_value   = ref_decoded[3:0];

    assign err_count_inc = (ErrorCount == 8'hFF) ? ErrorCount : ErrorCount + 8'd1;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            ref_q      <= '0;
            stable_q   <= '0;
            timeout_q  <= '0;
            Output     <= '0;
            Valid      <= 1'b0;
            Error      <= 1'b0;
            Busy       <= 1'b0;
            ErrorCount <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    Valid <= 1'b0;
                    if (Ready) begin
                        ref_q     <= seg;
                        stable_q  <= '0;
                        timeout_q <= '0;
                        Busy      <= 1'b1;
                        state_q   <= StSettle;
                    end
                end

                StSettle: begin
                    timeout_q <= timeout_inc;
                    if (matched) begin
                        stable_q <= stable_inc;
                    end else begin
                        ref_q    <= seg;
                        stable_q <= '0;
                    end

                    // A stable decode takes priority over a timeout on the same edge.
                    if (stable_hit) begin
                        state_q <= StDone;
                        Valid   <= 1'b1;
                        Output  <= ref_legal ? ref_value : 4'h0;
                        Error   <= ~ref_legal;
                        if (!ref_legal) begin
                            ErrorCount <= err_count_inc;
                        end
                    end else if (timeout_hit) begin
                        state_q    <= StDone;
                        Valid      <= 1'b1;
                        Output     <= 4'h0;
                        Error      <= 1'b1;
                        ErrorCount <= err_count_inc;
                    end
                end

                StDone: begin
                    Valid   <= 1'b0;
                    Busy    <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    Valid   <= 1'b0;
                    Busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
